// File: rtl/soc_irq_ctrl.sv
// soc_irq_ctrl: platform interrupt controller for six level-sensitive
// peripheral sources (IDs 1..6) with priority/enable/threshold and a
// claim/complete register, accessed over a Wishbone-style slave port.
module soc_irq_ctrl #(
  parameter int ADDR_W = 12,
  parameter int PRIO_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_irq,
  input  logic              spi_flash_irq,
  input  logic              spi2_irq,
  input  logic              gpio_irq,
  input  logic              i2c_irq,
  input  logic              ptc_irq,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  output logic              wb_ack_o,
  output logic              ext_irq_o
);

  localparam int NSRC = 6;
  localparam logic [ADDR_W-1:0] PEND_ADDR  = ADDR_W'('h080);
  localparam logic [ADDR_W-1:0] EN_ADDR    = ADDR_W'('h100);
  localparam logic [ADDR_W-1:0] THR_ADDR   = ADDR_W'('h200);
  localparam logic [ADDR_W-1:0] CLAIM_ADDR = ADDR_W'('h204);

  // Source vector indexed by interrupt ID (bit 0 unused, ID 0 means "none")
  logic [NSRC:1]     src;
  logic [NSRC:1]     pending;
  logic [NSRC:1]     in_service;
  logic [NSRC:1]     qualified;
  logic [NSRC:1]     hit_prio;
  logic [NSRC:1]     claim_sel;
  logic [NSRC:1]     complete_sel;
  logic [PRIO_W-1:0] prio [1:NSRC];

  logic [NSRC:1]     enable_reg;
  logic [PRIO_W-1:0] threshold_reg;
  logic              ack_reg;
  logic              ext_reg;
  logic [31:0]       dat_reg;

  logic [ADDR_W-1:0] word_adr;
  logic              access;
  logic              bus_rd;
  logic              bus_wr;
  logic              hit_pend;
  logic              hit_en;
  logic              hit_thr;
  logic              hit_claim;
  logic              claim_fire;
  logic              complete_fire;
  logic [2:0]        claim_id;
  logic [PRIO_W-1:0] best_prio;
  logic [31:0]       rdata;
  logic              unused_bits;

  assign src = {ptc_irq, i2c_irq, gpio_irq, spi2_irq, spi_flash_irq, uart_irq};

  // Byte lanes are ignored and accesses are word-aligned, so drop the low bits
  assign word_adr  = {wb_adr_i[ADDR_W-1:2], 2'b00};
  assign access    = wb_cyc_i && wb_stb_i && !ack_reg;
  assign bus_rd    = access && !wb_we_i;
  assign bus_wr    = access && wb_we_i;
  assign hit_pend  = (word_adr == PEND_ADDR);
  assign hit_en    = (word_adr == EN_ADDR);
  assign hit_thr   = (word_adr == THR_ADDR);
  assign hit_claim = (word_adr == CLAIM_ADDR);

  // A claim that finds nothing must not disturb any state
  assign claim_fire    = bus_rd && hit_claim && (claim_id != 3'd0);
  assign complete_fire = bus_wr && hit_claim;

  assign unused_bits = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i[31:7]};

  // Arbitration: strictly-greater compare keeps the lowest ID on ties and
  // starting from zero excludes priority-0 sources; threshold is not involved
  always_comb begin
    claim_id  = 3'd0;
    best_prio = '0;
    for (int i = 1; i <= NSRC; i++) begin
      if (pending[i] && enable_reg[i] && (prio[i] > best_prio)) begin
        best_prio = prio[i];
        claim_id  = 3'(i);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi <= NSRC; gi++) begin : g_src
      logic              pending_reg;
      logic              in_service_reg;
      logic [PRIO_W-1:0] prio_reg;

      assign hit_prio[gi]     = (word_adr == ADDR_W'(4 * gi));
      assign claim_sel[gi]    = claim_fire && (claim_id == 3'(gi));
      assign complete_sel[gi] = complete_fire && (wb_dat_i[2:0] == 3'(gi));

      // Level gateway and priority register; a claim beats a same-cycle re-set
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pending_reg    <= 1'b0;
          in_service_reg <= 1'b0;
          prio_reg       <= '0;
        end else begin
          if (claim_sel[gi])
            pending_reg <= 1'b0;
          else if (src[gi] && !in_service_reg)
            pending_reg <= 1'b1;
          if (claim_sel[gi])
            in_service_reg <= 1'b1;
          else if (complete_sel[gi])
            in_service_reg <= 1'b0;
          if (bus_wr && hit_prio[gi])
            prio_reg <= wb_dat_i[PRIO_W-1:0];
        end
      end

      assign pending[gi]    = pending_reg;
      assign in_service[gi] = in_service_reg;
      assign prio[gi]       = prio_reg;
      assign qualified[gi]  = pending_reg && enable_reg[gi] && (prio_reg > threshold_reg);
    end
  endgenerate

  // Read mux; priority[0] and unmapped words fall through to zero
  always_comb begin
    rdata = '0;
    for (int i = 1; i <= NSRC; i++) begin
      if (hit_prio[i])
        rdata[PRIO_W-1:0] = prio[i];
    end
    if (hit_pend)
      rdata = {25'd0, pending, 1'b0};
    if (hit_en)
      rdata = {25'd0, enable_reg, 1'b0};
    if (hit_thr)
      rdata[PRIO_W-1:0] = threshold_reg;
    if (hit_claim)
      rdata[2:0] = claim_id;
  end

  // Bus handshake, global registers and the registered interrupt request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_reg       <= 1'b0;
      dat_reg       <= '0;
      enable_reg    <= '0;
      threshold_reg <= '0;
      ext_reg       <= 1'b0;
    end else begin
      ack_reg <= access;
      dat_reg <= bus_rd ? rdata : 32'd0;
      if (bus_wr && hit_en)
        enable_reg <= wb_dat_i[NSRC:1];
      if (bus_wr && hit_thr)
        threshold_reg <= wb_dat_i[PRIO_W-1:0];
      ext_reg <= |qualified;
    end
  end

  assign wb_ack_o  = ack_reg;
  assign wb_dat_o  = dat_reg;
  assign ext_irq_o = ext_reg;

  // in_service has no read port; it is observable only through the gateway
  logic unused_in_service;
  assign unused_in_service = ^in_service;

endmodule

// File: tb/tb_soc_irq_ctrl.sv
// tb_soc_irq_ctrl: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural model of the interrupt controller.
module tb_soc_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uart_irq = 1'b0, spi_flash_irq = 1'b0, spi2_irq = 1'b0;
  logic        gpio_irq = 1'b0, i2c_irq = 1'b0, ptc_irq = 1'b0;
  logic [11:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = 4'hF;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_ack_o;
  logic        ext_irq_o;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;
  bit rnd_run = 1'b0;

  logic [11:0] zero_addrs [11] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014,
                                   12'h018, 12'h080, 12'h100, 12'h200, 12'h204};

  soc_irq_ctrl #(.ADDR_W(12), .PRIO_W(3)) dut (
    .clk(clk), .reset(reset),
    .uart_irq(uart_irq), .spi_flash_irq(spi_flash_irq), .spi2_irq(spi2_irq),
    .gpio_irq(gpio_irq), .i2c_irq(i2c_irq), .ptc_irq(ptc_irq),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o), .ext_irq_o(ext_irq_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_prio [7];
  bit          m_en   [7];
  bit          m_pend [7];
  bit          m_insv [7];
  int          m_thr = 0;
  bit          m_ack = 1'b0;
  bit          m_ext = 1'b0;
  bit          m_rvalid = 1'b0;
  logic [31:0] m_dat = '0;

  function automatic bit src_bit(int i);
    case (i)
      1: return uart_irq;
      2: return spi_flash_irq;
      3: return spi2_irq;
      4: return gpio_irq;
      5: return i2c_irq;
      6: return ptc_irq;
      default: return 1'b0;
    endcase
  endfunction

  // Highest priority among enabled pending sources, then the first ID holding it
  function automatic int m_claim();
    int maxp = 0;
    for (int i = 1; i <= 6; i++)
      if (m_pend[i] && m_en[i] && m_prio[i] > maxp) maxp = m_prio[i];
    if (maxp == 0) return 0;
    for (int i = 1; i <= 6; i++)
      if (m_pend[i] && m_en[i] && m_prio[i] == maxp) return i;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(logic [11:0] a);
    logic [31:0] r = '0;
    int w = int'(a) & 'hFFC;
    if (w >= 4 && w <= 24) r = m_prio[w / 4];
    else if (w == 'h080) begin for (int i = 1; i <= 6; i++) r[i] = m_pend[i]; end
    else if (w == 'h100) begin for (int i = 1; i <= 6; i++) r[i] = m_en[i]; end
    else if (w == 'h200) r = m_thr;
    else if (w == 'h204) r = m_claim();
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 7; i++) begin
      m_prio[i] = 0; m_en[i] = 0; m_pend[i] = 0; m_insv[i] = 0;
    end
    m_thr = 0; m_ack = 0; m_ext = 0; m_rvalid = 0; m_dat = '0;
  endtask

  task automatic model_step();
    bit acc, is_rd, is_wr, ext_n;
    int w, cid, c;
    logic [31:0] rd;
    bit np [7];
    bit ni [7];
    acc   = wb_cyc_i && wb_stb_i && !m_ack;
    is_rd = acc && !wb_we_i;
    is_wr = acc && wb_we_i;
    w     = int'(wb_adr_i) & 'hFFC;
    ext_n = 0;
    for (int i = 1; i <= 6; i++)
      if (m_pend[i] && m_en[i] && m_prio[i] > m_thr) ext_n = 1;
    cid = m_claim();
    rd  = m_read(wb_adr_i);
    for (int i = 0; i < 7; i++) begin
      np[i] = (i > 0) && (m_pend[i] || (src_bit(i) && !m_insv[i]));
      ni[i] = m_insv[i];
    end
    if (is_rd && w == 'h204 && cid != 0) begin
      np[cid] = 0;
      ni[cid] = 1;
    end
    if (is_wr) begin
      if (w >= 4 && w <= 24) m_prio[w / 4] = int'(wb_dat_i & 32'd7);
      else if (w == 'h100) begin for (int i = 1; i <= 6; i++) m_en[i] = wb_dat_i[i]; end
      else if (w == 'h200) m_thr = int'(wb_dat_i & 32'd7);
      else if (w == 'h204) begin
        c = int'(wb_dat_i & 32'd7);
        if (c >= 1 && c <= 6) ni[c] = 0;
      end
    end
    m_pend = np;
    m_insv = ni;
    m_ack = acc;
    m_rvalid = is_rd;
    m_dat = rd;
    m_ext = ext_n;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_clear();
      else model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Every cycle: DUT outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !reset) begin
        check("ack", {31'd0, wb_ack_o}, {31'd0, m_ack});
        check("ext", {31'd0, ext_irq_o}, {31'd0, m_ext});
        if (m_rvalid && wb_ack_o) check("rdata", wb_dat_o, m_dat);
      end
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus_xfer(input logic we, input logic [11:0] a, input logic [31:0] d,
                          output logic [31:0] q);
    int n;
    @(negedge clk);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = a; wb_dat_i = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb_ack_o && n < 8);
    if (!wb_ack_o) check("ack_timeout", {31'd0, wb_ack_o}, 32'd1);
    q = wb_dat_o;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    $display("[%0t] %s adr=%h wdata=%h rdata=%h", $time, we ? "WR" : "RD", a, d, q);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus_xfer(1'b1, a, d, q);
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] q;
    bus_xfer(1'b0, a, 32'd0, q);
    check(name, q, exp);
  endtask

  task automatic wait_ext(input string name, input logic exp, input int max_cyc);
    int n = 0;
    while (ext_irq_o !== exp && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, ext_irq_o}, {31'd0, exp});
  endtask

  task automatic sources_low();
    uart_irq = 0; spi_flash_irq = 0; spi2_irq = 0; gpio_irq = 0; i2c_irq = 0; ptc_irq = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    sources_low();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 11))
      0: return 12'h000;
      1: return 12'h004;
      2: return 12'h010;
      3: return 12'h018;
      4: return 12'h080;
      5: return 12'h100;
      6: return 12'h200;
      7: return 12'h204;
      8: return 12'h206;
      9: return 12'h084;
      10: return 12'h300;
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  task automatic random_xfer();
    logic [31:0] q;
    case ($urandom_range(0, 9))
      0, 1, 2: bus_xfer(1'b0, 12'h204, 32'd0, q);
      3: bus_xfer(1'b1, 12'h204, $urandom_range(0, 7), q);
      4: bus_xfer(1'b1, 12'(4 * $urandom_range(0, 6)), $urandom, q);
      5: bus_xfer(1'b1, 12'h100, $urandom, q);
      6: bus_xfer(1'b1, 12'h200, $urandom_range(0, 3), q);
      7: bus_xfer(1'b0, pick_addr(), 32'd0, q);
      default: bus_xfer(1'($urandom_range(0, 1)), pick_addr(), $urandom, q);
    endcase
  endtask

  task automatic toggle_sources();
    if ($urandom_range(0, 7) == 0) uart_irq = ~uart_irq;
    if ($urandom_range(0, 7) == 0) spi_flash_irq = ~spi_flash_irq;
    if ($urandom_range(0, 7) == 0) spi2_irq = ~spi2_irq;
    if ($urandom_range(0, 7) == 0) gpio_irq = ~gpio_irq;
    if ($urandom_range(0, 7) == 0) i2c_irq = ~i2c_irq;
    if ($urandom_range(0, 7) == 0) ptc_irq = ~ptc_irq;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_ext", {31'd0, ext_irq_o}, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    reset = 0;
    chk_en = 1;

    // Scenario 1: single source routed to the core
    @(negedge clk); ptc_irq = 1;
    wr(12'h018, 32'd1);
    wr(12'h200, 32'd0);
    wr(12'h100, 32'h40);
    wait_ext("t1_ext", 1'b1, 2);
    rd_chk("t1_pend", 12'h080, 32'h40);

    // Scenario 2: claim
    rd_chk("t2_claim", 12'h204, 32'd6);
    @(negedge clk);
    check("t2_ext_drop", {31'd0, ext_irq_o}, 32'd0);
    rd_chk("t2_pend", 12'h080, 32'h00);

    // Scenario 3: complete with a wrong then the right ID
    wr(12'h204, 32'd3);
    repeat (3) @(negedge clk);
    check("t3_ext_bad_id", {31'd0, ext_irq_o}, 32'd0);
    wr(12'h204, 32'd6);
    wait_ext("t3_ext_rearm", 1'b1, 2);
    rd_chk("t3_pend", 12'h080, 32'h40);

    // Scenario 4: threshold masking
    wr(12'h018, 32'd2);
    wr(12'h200, 32'd2);
    repeat (3) @(negedge clk);
    check("t4_ext_masked", {31'd0, ext_irq_o}, 32'd0);
    wr(12'h200, 32'd1);
    wait_ext("t4_ext_unmasked", 1'b1, 2);
    wr(12'h200, 32'd2);
    repeat (2) @(negedge clk);
    rd_chk("t4_claim_masked", 12'h204, 32'd6);
    wr(12'h204, 32'd6);

    // Scenario 5: arbitration
    do_reset();
    wr(12'h004, 32'd3);
    wr(12'h010, 32'd5);
    wr(12'h018, 32'd5);
    wr(12'h100, 32'h7E);
    @(negedge clk); uart_irq = 1; gpio_irq = 1; ptc_irq = 1;
    repeat (2) @(negedge clk);
    rd_chk("t5_claim_a", 12'h204, 32'd4);
    rd_chk("t5_claim_b", 12'h204, 32'd6);
    rd_chk("t5_claim_c", 12'h204, 32'd1);
    rd_chk("t5_claim_none", 12'h204, 32'd0);
    rd_chk("t5_pend_empty", 12'h080, 32'h00);
    wr(12'h204, 32'd4);
    wr(12'h204, 32'd6);
    wr(12'h204, 32'd1);
    repeat (2) @(negedge clk);
    rd_chk("t5_pend_rearm", 12'h080, 32'h52);
    wr(12'h100, 32'h00);
    rd_chk("t5_claim_disabled", 12'h204, 32'd0);
    wait_ext("t5_ext_off", 1'b0, 2);
    wr(12'h100, 32'h7E);
    rd_chk("t5_claim_again", 12'h204, 32'd4);
    rd_chk("t5_pend_after", 12'h080, 32'h42);
    wait_ext("t5_ext_on", 1'b1, 2);

    // Scenario 6: asynchronous reset in the middle of a claim access
    @(negedge clk);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 12'h204;
    #2 reset = 1;
    #1;
    check("t6_ack_async", {31'd0, wb_ack_o}, 32'd0);
    check("t6_ext_async", {31'd0, ext_irq_o}, 32'd0);
    check("t6_dat_async", wb_dat_o, 32'd0);
    @(negedge clk);
    check("t6_ack_held", {31'd0, wb_ack_o}, 32'd0);
    wb_cyc_i = 0; wb_stb_i = 0;
    sources_low();
    @(negedge clk); reset = 0;
    for (int i = 0; i < 11; i++) rd_chk("t6_zero", zero_addrs[i], 32'd0);
    wr(12'h000, 32'd7);
    rd_chk("t6_prio0", 12'h000, 32'd0);

    // Randomized traffic with toggling sources
    do_reset();
    rnd_run = 1;
    fork
      begin
        while (rnd_run) begin
          @(negedge clk);
          toggle_sources();
        end
      end
      begin
        for (int k = 0; k < 250; k++) begin
          random_xfer();
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int k = 0; k < 300; k++) begin
          @(negedge clk);
          wb_cyc_i = ($urandom_range(0, 3) != 0);
          wb_stb_i = ($urandom_range(0, 3) != 0);
          wb_we_i  = 1'($urandom_range(0, 1));
          wb_adr_i = pick_addr();
          wb_dat_i = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 7)) : $urandom;
        end
        @(negedge clk);
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        rnd_run = 0;
      end
    join
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
